key_event_queue: RTL and testbench
==================================

# key_event_queue

Collects the single-cycle press/release flags produced by the per-key debouncers and turns them into an ordered queue of key events for the tone/playback logic. Each key has a one-deep pending slot, a fixed-priority arbiter moves pending events into a small FIFO, and a valid/ready interface drains the FIFO. The block also maintains a held-key mask that reflects every event it has queued.

## Interface

- NKEYS, 8, number of key channels; must be ≤ 2^KW
- KW, 3, key index width
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- press_flag  in  NKEYS  one-cycle pulse per key on debounced press
- release_flag  in  NKEYS  one-cycle pulse per key on debounced release
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_key  out  KW  key index of the head event
- ev_press  out  1  1 = press, 0 = release
- held  out  NKEYS  held-key mask, updated as events are queued
- count  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; set when any event is dropped
- ovf_clr  in  1  synchronous clear of overflow

## Operation

- Reset: all pending slots empty, FIFO empty, rd/wr pointers 0; outputs ev_valid=0, ev_key=0, ev_press=0, held=0, count=0, overflow=0.
- Capture: on each edge, a key with press_flag=1 or release_flag=1 loads its pending slot (valid=1, type=press). If both flags are high for the same key in the same cycle, press wins and overflow is set.
- If the slot is already valid and not being drained on that edge, the new flag is dropped and overflow is set. The older event is kept.
- Arbiter: each cycle it selects the lowest-index valid pending slot. If the FIFO is not full, it writes {key, type} (plus timestamp when enabled), clears that slot, and updates held: a press sets held[key], a release clears it.
- The arbiter writes at most one event per cycle.
- A slot cleared by the arbiter and newly captured on the same edge ends up valid with the new event. The capture is not counted as an overflow.
- FIFO is show-ahead: ev_key, ev_press and ev_time reflect the head whenever ev_valid=1. ev_valid = (count≠0).
- A pop occurs when ev_valid and ev_ready are both 1. Outputs hold stable while ev_valid=1 and ev_ready=0.
- Full: no write occurs while count=DEPTH, even if a pop happens in the same cycle. Pending slots simply wait, so there is no loss unless a slot is re-flagged.
- Push and pop in the same non-full cycle leave count unchanged.
- Pointers are clog2(DEPTH) bits wide and wrap naturally.
- ovf_clr=1 clears overflow on the next edge, unless a drop occurs in the same cycle; the set has priority.

## Timing

- A flag at edge k appears in the pending slot after edge k.
- With the FIFO not full and no lower-index slot pending, the event is written at edge k+1. ev_valid is therefore high in the cycle after edge k+1: 2-cycle latency from flag to ev_valid.
- held updates on the same edge as the FIFO write.
- Reset may assert mid-operation. It clears everything immediately and asynchronously; in-flight and pending events are discarded.

## Configuration

- KEY_EVT_TIMESTAMP_EN defined: a free-running 16-bit cycle counter is present.
  - Reset value 0; it wraps from 0xFFFF to 0.
  - Its value is latched into the pending slot on the capture edge and carried through the FIFO.
  - The value is output on port ev_time [15:0] for the head event.
- Not defined: there is no counter, no timestamp storage, and no ev_time port. All other behaviour is identical.

## Test plan

- Reset then idle: after rst released, ev_valid=0, held=0, count=0, overflow=0 for 20 cycles.
- Single event: press_flag[5] pulse at edge k with ev_ready=1 → ev_valid=1 after edge k+1 with ev_key=5, ev_press=1, held=0x20. Then a release_flag[5] pulse → ev_press=0, held=0x00.
- Simultaneous keys: press_flag=0x0B in one cycle with ev_ready=0 → FIFO order ev_key 0, 1, 3 on successive pops, and count reaches 3.
- Full/backpressure: ev_ready=0, 8 press pulses on keys 0–7 over spaced cycles, then 1 release on key 0. Expected: count=8 and key 0's release stays pending. After one pop, the release is written and count=8 again. overflow stays 0.
- Overflow: while the FIFO is full, pulse press_flag[2] twice → overflow=1 and only one key-2 event is queued later. ovf_clr=1 for one cycle → overflow=0.
- Timestamp (with KEY_EVT_TIMESTAMP_EN): press_flag[1] captured when the counter is 0xFFFF, then press_flag[2] one cycle later → ev_time 0xFFFF then 0x0000.

Source files
------------

// File: rtl/key_event_queue.sv
// Queues debounced key press/release flags into an ordered event FIFO and tracks the held-key mask.
// Latency: flag at edge k -> pending slot after k -> FIFO write at k+1, so ev_valid is high 2 cycles after the flag.
// Backpressure: ev_valid/ev_ready drain; a full FIFO stalls the arbiter, and a re-flagged busy slot is dropped (sticky overflow).
// Optional feature: KEY_EVT_TIMESTAMP_EN adds a 16-bit free-running cycle stamp carried with each event on ev_time.
module key_event_queue #(
    parameter int NKEYS = 8,
    parameter int KW    = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NKEYS-1:0]         press_flag,
    input  logic [NKEYS-1:0]         release_flag,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [KW-1:0]            ev_key,
    output logic                     ev_press,
`ifdef KEY_EVT_TIMESTAMP_EN
    output logic [15:0]              ev_time,
`endif
    output logic [NKEYS-1:0]         held,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
`ifdef KEY_EVT_TIMESTAMP_EN
        logic [15:0] ts;
`endif
        logic [KW-1:0] key;
        logic          press;
    } entry_t;

    // Pending slots, one per key
    logic [NKEYS-1:0] slot_vld_q, slot_vld_d;
    logic [NKEYS-1:0] slot_press_q, slot_press_d;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0]      slot_ts_q [NKEYS];
    logic [15:0]      slot_ts_d [NKEYS];
    logic [15:0]      ts_q, ts_d;
`endif

    // FIFO state
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [NKEYS-1:0] held_q, held_d;
    logic             overflow_q, overflow_d;

    // Arbiter outputs
    logic [NKEYS-1:0] grant;
    logic [NKEYS-1:0] drain;
    logic             sel_vld;
    logic [KW-1:0]    sel_key;
    logic             sel_press;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0]      sel_ts;
`endif
    logic             push;
    logic             pop;
    logic             drop;
    logic             flag_any;
    entry_t           wr_entry;
    entry_t           head;

    // Fixed-priority arbiter: lowest-index pending slot wins
    always_comb begin
        grant     = '0;
        sel_vld   = 1'b0;
        sel_key   = '0;
        sel_press = 1'b0;
`ifdef KEY_EVT_TIMESTAMP_EN
        sel_ts    = '0;
`endif
        for (int i = 0; i < NKEYS; i++) begin
            if (slot_vld_q[i] && !sel_vld) begin
                sel_vld   = 1'b1;
                grant[i]  = 1'b1;
                sel_key   = KW'(i);
                sel_press = slot_press_q[i];
`ifdef KEY_EVT_TIMESTAMP_EN
                sel_ts    = slot_ts_q[i];
`endif
            end
        end
        // A full FIFO blocks the write even if a pop happens this cycle
        push  = sel_vld && (count_q != FULL_CNT);
        drain = push ? grant : '0;
        pop   = (count_q != '0) && ev_ready;
    end

    // Slot capture/drain and overflow detection
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_press_d = slot_press_q;
`ifdef KEY_EVT_TIMESTAMP_EN
        slot_ts_d    = slot_ts_q;
`endif
        drop     = 1'b0;
        flag_any = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            flag_any = press_flag[i] || release_flag[i];
            // Conflicting flags: press wins but the release is lost
            if (press_flag[i] && release_flag[i]) begin
                drop = 1'b1;
            end
            if (flag_any) begin
                if (slot_vld_q[i] && !drain[i]) begin
                    // Older event is kept; the new one is lost
                    drop = 1'b1;
                end else begin
                    slot_vld_d[i]   = 1'b1;
                    slot_press_d[i] = press_flag[i];
`ifdef KEY_EVT_TIMESTAMP_EN
                    slot_ts_d[i]    = ts_q;
`endif
                end
            end else if (drain[i]) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    // FIFO pointers/occupancy, held mask, sticky overflow, cycle stamp
    always_comb begin
        wr_entry       = '0;
        wr_entry.key   = sel_key;
        wr_entry.press = sel_press;
`ifdef KEY_EVT_TIMESTAMP_EN
        wr_entry.ts    = sel_ts;
        ts_d           = ts_q + 16'd1;
`endif
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        held_d   = held_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            held_d          = sel_press ? (held_q | grant) : (held_q & ~grant);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld_q   <= '0;
            slot_press_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            held_q       <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef KEY_EVT_TIMESTAMP_EN
            ts_q <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                slot_ts_q[i] <= '0;
            end
`endif
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_press_q <= slot_press_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            held_q       <= held_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
`ifdef KEY_EVT_TIMESTAMP_EN
            ts_q      <= ts_d;
            slot_ts_q <= slot_ts_d;
`endif
        end
    end

    // Show-ahead head; fields forced to zero while the FIFO is empty
    always_comb begin
        head     = mem_q[rd_ptr_q];
        ev_valid = (count_q != '0);
        ev_key   = ev_valid ? head.key : '0;
        ev_press = ev_valid ? head.press : 1'b0;
`ifdef KEY_EVT_TIMESTAMP_EN
        ev_time  = ev_valid ? head.ts : '0;
`endif
        held     = held_q;
        count    = count_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] press_flag;
    logic [7:0] release_flag;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_key;
    logic       ev_press;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0] ev_time;
`endif
    logic [7:0] held;
    logic [3:0] count;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    key_event_queue #(.NKEYS(8), .KW(3), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_key       (ev_key),
        .ev_press     (ev_press),
`ifdef KEY_EVT_TIMESTAMP_EN
        .ev_time      (ev_time),
`endif
        .held         (held),
        .count        (count),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_key [9]   = '{1, 2, 3, 4, 5, 6, 7, 0, 2};
    int exp_press [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};

    initial begin
        rst = 1'b0; press_flag = '0; release_flag = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        chk("in_reset", {27'd0, ev_valid, overflow, count}, 32'd0);
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {ev_valid, overflow, held, ev_key, ev_press, count}, 32'd0);
        end

        // Single press then release on key 5
        ev_ready = 1'b1;
        press_flag = 8'h20;
        tick();
        press_flag = '0;
        chk("lat_k_valid", ev_valid, 0);
        tick();
        chk("single_valid", ev_valid, 1);
        chk("single_key", ev_key, 5);
        chk("single_press", ev_press, 1);
        chk("single_held", held, 8'h20);
        release_flag = 8'h20;
        tick();
        release_flag = '0;
        chk("popped_empty", ev_valid, 0);
        tick();
        chk("rel_valid", ev_valid, 1);
        chk("rel_key", ev_key, 5);
        chk("rel_press", ev_press, 0);
        chk("rel_held", held, 8'h00);
        tick();
        chk("rel_drained", count, 0);

        // Simultaneous keys 0,1,3 with consumer stalled
        ev_ready = 1'b0;
        press_flag = 8'h0B;
        tick();
        press_flag = '0;
        tick(); tick(); tick();
        chk("simul_count", count, 3);
        chk("simul_held", held, 8'h0B);
        chk("simul_head0", ev_key, 0);
        tick();
        chk("simul_stall_key", ev_key, 0);
        chk("simul_stall_cnt", count, 3);
        ev_ready = 1'b1;
        tick();
        chk("simul_head1", ev_key, 1);
        tick();
        chk("simul_head3", ev_key, 3);
        tick();
        chk("simul_empty", ev_valid, 0);
        ev_ready = 1'b0;

        // Fill the FIFO with presses on keys 0..7, then a pending release on key 0
        for (int i = 0; i < 8; i++) begin
            press_flag = 8'(1 << i);
            tick();
            press_flag = '0;
            tick();
        end
        release_flag = 8'h01;
        tick();
        release_flag = '0;
        tick(); tick();
        chk("full_count", count, 8);
        chk("full_head", {ev_key, ev_press}, {3'd0, 1'b1});
        chk("full_held", held, 8'hFF);
        chk("full_ovf", overflow, 0);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("full_pop_count", count, 7);
        chk("full_pop_held", held, 8'hFF);
        tick();
        chk("full_refill", count, 8);
        chk("full_rel_held", held, 8'hFE);
        chk("full_ovf2", overflow, 0);

        // Re-flag key 2 while its slot waits on a full FIFO
        press_flag = 8'h04;
        tick();
        press_flag = '0;
        chk("ovf_first_ok", overflow, 0);
        tick();
        press_flag = 8'h04;
        tick();
        press_flag = '0;
        chk("ovf_set", overflow, 1);
        tick();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_count", count, 8);
        ev_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            chk("drain_key", ev_key, exp_key[j]);
            chk("drain_press", ev_press, exp_press[j]);
            tick();
        end
        ev_ready = 1'b0;
        chk("drain_empty", ev_valid, 0);
        chk("drain_held", held, 8'hFE);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Conflicting flags with a clear in the same cycle: set wins, press wins
        ovf_clr = 1'b1;
        press_flag = 8'h40;
        release_flag = 8'h40;
        tick();
        ovf_clr = 1'b0;
        press_flag = '0;
        release_flag = '0;
        chk("ovf_set_wins", overflow, 1);
        tick();
        chk("both_key", {ev_valid, ev_key, ev_press}, {1'b1, 3'd6, 1'b1});
        chk("both_count", count, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", overflow, 0);

        // Mid-operation reset discards queued and pending events
        press_flag = 8'h81;
        tick();
        press_flag = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst", {ev_valid, overflow, held, count}, 32'd0);
        #1;
        rst = 1'b1;
        tick(); tick(); tick();
        chk("post_rst", {ev_valid, held, count}, 32'd0);

`ifdef KEY_EVT_TIMESTAMP_EN
        // Counter is 0 after the reset above; 65535 edges bring it to 0xFFFF
        repeat (65535 - 3) tick();
        ev_ready = 1'b0;
        press_flag = 8'h02;
        tick();
        press_flag = 8'h04;
        tick();
        press_flag = '0;
        tick(); tick();
        chk("ts_count", count, 2);
        chk("ts_first", ev_time, 16'hFFFF);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("ts_second_key", ev_key, 2);
        chk("ts_second", ev_time, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
